// File: rtl/va_vn_n_to_m_pkg.sv
// Shared types and default sizing for the multi-VN VC allocator.
// The defaults match the NIC-wide buffer, VN and VC counts.
package va_vn_n_to_m_pkg;

  localparam int DEF_N_FIFO_OUT_BUFFER = 4;
  localparam int DEF_N_OF_VC           = 2;
  localparam int DEF_N_OF_VN           = 2;

  typedef enum logic {
    VC_IDLE  = 1'b0,
    VC_ALLOC = 1'b1
  } vc_state_e;

  // Index width helper: never returns 0, so one-entry configurations still get a 1-bit field.
  function automatic int clog2_min1(input int value);
    return (value <= 2) ? 1 : $clog2(value);
  endfunction

endpackage

// File: rtl/va_vn_n_to_m_rr_arbiter.sv
// Round-robin arbiter: the search starts at the pointer, and the pointer moves past the winner
// only when a grant is actually issued.
module rr_arbiter
  import va_vn_n_to_m_pkg::*;
#(
  parameter int N_OF_REQUEST = DEF_N_FIFO_OUT_BUFFER
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_OF_REQUEST-1:0] req_i,
  input  logic                    en_i,
  output logic [N_OF_REQUEST-1:0] grant_o
);

  localparam int PTR_W = clog2_min1(N_OF_REQUEST);

  logic [PTR_W-1:0] ptr;
  logic [PTR_W-1:0] ptr_next;
  int               best;
  int               best_dist;

  // Rotational distance from the pointer; the closest requester wins.
  always_comb begin
    best      = 0;
    best_dist = N_OF_REQUEST;
    for (int r = 0; r < N_OF_REQUEST; r++) begin
      if (req_i[r] && (((r + N_OF_REQUEST - int'(ptr)) % N_OF_REQUEST) < best_dist)) begin
        best      = r;
        best_dist = (r + N_OF_REQUEST - int'(ptr)) % N_OF_REQUEST;
      end
    end
  end

  always_comb begin
    grant_o  = '0;
    ptr_next = ptr;
    if (en_i && (best_dist < N_OF_REQUEST)) begin
      for (int r = 0; r < N_OF_REQUEST; r++) begin
        grant_o[r] = (r == best);
      end
      ptr_next = PTR_W'((best + 1) % N_OF_REQUEST);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      ptr <= '0;
    end else begin
      ptr <= ptr_next;
    end
  end

endmodule

// File: rtl/va_vn_n_to_m.sv
// Multi-virtual-network VC allocator: one round-robin arbiter per VN.
// Each VN hands its lowest free VC to one buffer per cycle and keeps it owned until release.
module va_vn_n_to_m
  import va_vn_n_to_m_pkg::*;
#(
  parameter int N_OF_REQUEST      = DEF_N_FIFO_OUT_BUFFER,
  parameter int N_OF_VN           = DEF_N_OF_VN,
  parameter int N_OF_VC           = DEF_N_OF_VC,
  parameter int N_BITS_OF_REQUEST = clog2_min1(N_OF_REQUEST),
  parameter int N_BITS_OF_VN      = clog2_min1(N_OF_VN)
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [N_OF_REQUEST-1:0]              r_va_vn_i,
  input  logic [N_OF_REQUEST*N_BITS_OF_VN-1:0] vn_id_i,
  input  logic [N_OF_REQUEST-1:0]              release_i,
  input  logic [N_OF_VN*N_OF_VC-1:0]           vc_free_i,
  output logic [N_OF_REQUEST-1:0]              g_va_vn_o,
  output logic [N_OF_REQUEST*N_OF_VC-1:0]      g_vc_o,
  output logic [N_OF_VN*N_OF_VC-1:0]           vc_busy_o
);

  localparam int N_VC_TOTAL = N_OF_VN * N_OF_VC;

  vc_state_e                     vc_state [N_VC_TOTAL];
  logic [N_BITS_OF_REQUEST-1:0]  vc_owner [N_VC_TOTAL];
  logic [N_OF_REQUEST*N_OF_VC-1:0] g_vc_q;
  logic [N_OF_REQUEST*N_OF_VC-1:0] g_vc_next;
  logic [N_OF_REQUEST-1:0]       g_va_vn_q;
  logic [N_OF_REQUEST-1:0]       grant_any;
  logic [N_OF_REQUEST-1:0]       holding;
  logic [N_VC_TOTAL-1:0]         allocatable;
  logic [N_VC_TOTAL-1:0]         released;
  logic [N_VC_TOTAL-1:0]         vc_take;
  logic [N_OF_REQUEST-1:0]       eligible  [N_OF_VN];
  logic [N_OF_REQUEST-1:0]       arb_grant [N_OF_VN];
  logic [N_OF_VC-1:0]            vc_pick   [N_OF_VN];
  logic [N_BITS_OF_REQUEST-1:0]  win_idx   [N_OF_VN];

  always_comb begin
    holding = '0;
    for (int r = 0; r < N_OF_REQUEST; r++) begin
      holding[r] = |g_vc_q[r*N_OF_VC +: N_OF_VC];
    end
  end

  // Out-of-range VN ids match no VN and are therefore silently dropped.
  always_comb begin
    for (int v = 0; v < N_OF_VN; v++) begin
      eligible[v] = '0;
      for (int r = 0; r < N_OF_REQUEST; r++) begin
        eligible[v][r] = r_va_vn_i[r] && !holding[r] && !release_i[r]
                       && (int'(vn_id_i[r*N_BITS_OF_VN +: N_BITS_OF_VN]) == v)
                       && (int'(vn_id_i[r*N_BITS_OF_VN +: N_BITS_OF_VN]) < N_OF_VN);
      end
    end
  end

  always_comb begin
    allocatable = '0;
    released    = '0;
    for (int i = 0; i < N_VC_TOTAL; i++) begin
      allocatable[i] = (vc_state[i] == VC_IDLE) && vc_free_i[i];
      for (int r = 0; r < N_OF_REQUEST; r++) begin
        if ((vc_state[i] == VC_ALLOC) && (vc_owner[i] == N_BITS_OF_REQUEST'(r)) && release_i[r]) begin
          released[i] = 1'b1;
        end
      end
    end
  end

  for (genvar v = 0; v < N_OF_VN; v++) begin : g_vn
    rr_arbiter #(
      .N_OF_REQUEST(N_OF_REQUEST)
    ) u_arb (
      .clk     (clk),
      .rst     (rst),
      .req_i   (eligible[v]),
      .en_i    (|allocatable[v*N_OF_VC +: N_OF_VC]),
      .grant_o (arb_grant[v])
    );
  end

  always_comb begin
    for (int v = 0; v < N_OF_VN; v++) begin
      vc_pick[v] = '0;
      win_idx[v] = '0;
      for (int c = 0; c < N_OF_VC; c++) begin
        if (allocatable[v*N_OF_VC + c] && (vc_pick[v] == '0)) begin
          vc_pick[v][c] = 1'b1;
        end
      end
      for (int r = 0; r < N_OF_REQUEST; r++) begin
        if (arb_grant[v][r]) begin
          win_idx[v] = N_BITS_OF_REQUEST'(r);
        end
      end
    end
  end

  // A buffer can be granted and released in the same cycle only in disjoint cases, so order is free.
  always_comb begin
    vc_take   = '0;
    grant_any = '0;
    g_vc_next = g_vc_q;
    for (int v = 0; v < N_OF_VN; v++) begin
      grant_any = grant_any | arb_grant[v];
      for (int c = 0; c < N_OF_VC; c++) begin
        vc_take[v*N_OF_VC + c] = (|arb_grant[v]) && vc_pick[v][c];
      end
    end
    for (int r = 0; r < N_OF_REQUEST; r++) begin
      if (release_i[r]) begin
        g_vc_next[r*N_OF_VC +: N_OF_VC] = '0;
      end
      for (int v = 0; v < N_OF_VN; v++) begin
        if (arb_grant[v][r]) begin
          g_vc_next[r*N_OF_VC +: N_OF_VC] = vc_pick[v];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      g_va_vn_q <= '0;
      g_vc_q    <= '0;
      for (int i = 0; i < N_VC_TOTAL; i++) begin
        vc_state[i] <= VC_IDLE;
        vc_owner[i] <= '0;
      end
    end else begin
      g_va_vn_q <= grant_any;
      g_vc_q    <= g_vc_next;
      for (int i = 0; i < N_VC_TOTAL; i++) begin
        if (released[i]) begin
          vc_state[i] <= VC_IDLE;
        end else if (vc_take[i]) begin
          vc_state[i] <= VC_ALLOC;
          vc_owner[i] <= win_idx[i / N_OF_VC];
        end
      end
    end
  end

  always_comb begin
    vc_busy_o = '0;
    for (int i = 0; i < N_VC_TOTAL; i++) begin
      vc_busy_o[i] = (vc_state[i] == VC_ALLOC);
    end
  end

  assign g_va_vn_o = g_va_vn_q;
  assign g_vc_o    = g_vc_q;

endmodule
